ecl_ram_array: RTL and testbench

ECL_RAM_ARRAY -- requirements
Module: ecl_ram_array

---
 rtl/ecl_ram_array_pkg.sv | 18 +
 rtl/ecl_ram_core.sv | 30 +++
 rtl/ecl_ram_array.sv | 132 +++++++++++++
 tb/tb_ecl_ram_array.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ecl_ram_array_pkg.sv
// Shared types and helpers for the parity-protected RAM array: controller
// states and the odd-parity generator used on the write path.
package ecl_ram_array_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int MAX_WIDTH = 72;

  // Odd parity: returns the bit that makes {data, bit} contain an odd number
  // of ones. Callers zero-extend narrower words, which leaves the XOR intact.
  function automatic logic odd_par(input logic [MAX_WIDTH-1:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ecl_ram_core.sv
// Plain single-port synchronous array: one write or one registered read per
// cycle. Contents are never reset; zeroing is the controller's job.
module ecl_ram_core #(
  parameter int W     = 37,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ecl_ram_array.sv
// Parity-protected single-port RAM with a post-reset clear sweep, registered
// read data and selectable read-during-write output behaviour.
module ecl_ram_array
  import ecl_ram_array_pkg::*;
#(
  parameter int WIDTH    = 36,
  parameter int DEPTH    = 1024,
  parameter int RDW_MODE = 0,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] d,
  input  logic             inj_par,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             par_err,
  output logic             busy,
  output state_t           dbg_state
);

  // Access protocol: no handshake. While busy is low, en=1 performs exactly
  // one access at the rising edge (we=1 write, we=0 read); results appear on
  // q/q_valid/par_err the following cycle. While busy is high all access
  // inputs are ignored and the outputs are held low.

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    w_cnt_nxt;

  logic             w_core_we;
  logic             w_core_re;
  logic [AW-1:0]    w_core_addr;
  logic [WIDTH:0]   w_core_wdata;
  logic [WIDTH:0]   w_core_rdata;
  logic             w_acc_rd;
  logic             w_acc_wr;
  logic             w_par_in;

  logic             r_rd_v;
  logic             r_wt_v;
  logic [WIDTH-1:0] r_wt_d;

  assign w_par_in = odd_par(MAX_WIDTH'(d)) ^ inj_par;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_core_we    = 1'b0;
    w_core_re    = 1'b0;
    w_core_addr  = addr;
    w_core_wdata = {w_par_in, d};
    w_acc_rd     = 1'b0;
    w_acc_wr     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        // Zero data carries parity 1 so swept words read back clean.
        w_core_we    = 1'b1;
        w_core_addr  = r_cnt;
        w_core_wdata = {1'b1, {WIDTH{1'b0}}};
        w_cnt_nxt    = r_cnt + 1'b1;
        if (r_cnt == AW'(DEPTH - 1)) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (en) begin
          if (we) begin
            w_core_we = 1'b1;
            w_acc_wr  = 1'b1;
          end else begin
            w_core_re = 1'b1;
            w_acc_rd  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_rd_v  <= 1'b0;
      r_wt_v  <= 1'b0;
      r_wt_d  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rd_v  <= w_acc_rd;
      r_wt_v  <= w_acc_wr;
      r_wt_d  <= w_acc_wr ? d : '0;
    end
  end

  ecl_ram_core #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_core (
    .clk     (clk),
    .i_addr  (w_core_addr),
    .i_we    (w_core_we),
    .i_re    (w_core_re),
    .i_wdata (w_core_wdata),
    .o_rdata (w_core_rdata)
  );

  // The core's read register is not reset, so its value is only exposed when
  // a read was actually issued in the previous cycle.
  always_comb begin
    q = '0;
    if (r_rd_v) begin
      q = w_core_rdata[WIDTH-1:0];
    end else if ((RDW_MODE != 0) && r_wt_v) begin
      q = r_wt_d;
    end
  end

  assign q_valid   = r_rd_v;
  assign par_err   = r_rd_v & ~(^w_core_rdata);
  assign busy      = (r_state == ST_CLEAR);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ecl_ram_array.sv
// Randomised self-checking bench for ecl_ram_array: both read-during-write
// modes run side by side against an array-based reference model.
module tb_ecl_ram_array;
  import ecl_ram_array_pkg::*;

  localparam int WIDTH = 36;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             we;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] d;
  logic             inj_par;

  logic [WIDTH-1:0] q0, q1;
  logic             qv0, qv1, pe0, pe1, busy0, busy1;
  state_t           st0, st1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: word contents, a corrupted-parity flag per word, and the
  // number of clear cycles still to run.
  logic [WIDTH-1:0] m_data [DEPTH];
  logic             m_bad  [DEPTH];
  int               m_busy;

  ecl_ram_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .d(d),
    .inj_par(inj_par), .q(q0), .q_valid(qv0), .par_err(pe0), .busy(busy0),
    .dbg_state(st0)
  );

  ecl_ram_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .d(d),
    .inj_par(inj_par), .q(q1), .q_valid(qv1), .par_err(pe1), .busy(busy1),
    .dbg_state(st1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic [WIDTH-1:0] e_q0, input logic [WIDTH-1:0] e_q1,
                               input logic e_v, input logic e_pe, input logic e_busy);
    chk("q_mode0", 64'(q0), 64'(e_q0));
    chk("q_mode1", 64'(q1), 64'(e_q1));
    chk("q_valid_mode0", 64'(qv0), 64'(e_v));
    chk("q_valid_mode1", 64'(qv1), 64'(e_v));
    chk("par_err_mode0", 64'(pe0), 64'(e_pe));
    chk("par_err_mode1", 64'(pe1), 64'(e_pe));
    chk("busy_mode0", 64'(busy0), 64'(e_busy));
    chk("busy_mode1", 64'(busy1), 64'(e_busy));
  endtask

  // Asserts reset between edges, checks the outputs drop at once, releases
  // it #1 after the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_outputs('0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i] = '0;
      m_bad[i]  = 1'b0;
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_busy = DEPTH;
    chk("busy_at_release", 64'(busy0 & busy1), 64'(1));
  endtask

  // Driver: one clock of stimulus, with the model predicting the result.
  task automatic cycle(input logic i_en, input logic i_we, input logic [AW-1:0] i_a,
                       input logic [WIDTH-1:0] i_d, input logic i_inj);
    logic [WIDTH-1:0] e_q0, e_q1;
    logic e_v, e_pe;
    en = i_en; we = i_we; addr = i_a; d = i_d; inj_par = i_inj;
    e_q0 = '0; e_q1 = '0; e_v = 1'b0; e_pe = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
    end else if (i_en && i_we) begin
      m_data[i_a] = i_d;
      m_bad[i_a]  = i_inj;
      e_q1        = i_d;
    end else if (i_en) begin
      e_q0 = m_data[i_a];
      e_q1 = m_data[i_a];
      e_v  = 1'b1;
      e_pe = m_bad[i_a];
    end
    @(posedge clk);
    #1;
    check_outputs(e_q0, e_q1, e_v, e_pe, m_busy > 0);
  endtask

  task automatic rand_cycle();
    logic [WIDTH-1:0] rd;
    rd = {4'($urandom), 32'($urandom)};
    cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          AW'($urandom_range(0, DEPTH - 1)), rd, $urandom_range(0, 7) == 0);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      cycle(1'b1, 1'b0, AW'(a), '0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; we = 1'b0; addr = '0; d = '0; inj_par = 1'b0;
    m_busy = 0;
    #2;
    do_reset();
    // Sweep with random accesses that must be ignored.
    for (int i = 0; i < DEPTH; i++) rand_cycle();
    read_all();

    cycle(1'b1, 1'b1, 4'd5, 36'h123456789, 1'b0);
    cycle(1'b1, 1'b0, 4'd5, '0, 1'b0);
    cycle(1'b1, 1'b1, 4'd7, 36'hFFFFFFFFF, 1'b1);
    cycle(1'b1, 1'b0, 4'd7, '0, 1'b0);
    cycle(1'b1, 1'b0, 4'd6, '0, 1'b0);
    cycle(1'b1, 1'b1, 4'd3, 36'hABC, 1'b0);
    cycle(1'b0, 1'b1, 4'd2, 36'h1, 1'b0);
    cycle(1'b1, 1'b0, 4'd2, '0, 1'b0);
    cycle(1'b1, 1'b0, 4'd3, '0, 1'b0);

    // Abort the sweep halfway; it must restart and run a full DEPTH cycles.
    do_reset();
    for (int i = 0; i < DEPTH / 2; i++) rand_cycle();
    do_reset();
    for (int i = 0; i < DEPTH; i++) rand_cycle();
    read_all();

    for (int i = 0; i < 400; i++) rand_cycle();

    // Reset while a read result is on the outputs.
    cycle(1'b1, 1'b1, 4'd9, 36'h5A5A5A5A5, 1'b1);
    cycle(1'b1, 1'b0, 4'd9, '0, 1'b0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) rand_cycle();
    read_all();
    for (int i = 0; i < 100; i++) rand_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
